// File: rtl/slink_tx_arb_if.sv
// S-Link TX arbiter bundle: requester-side packet ports plus the
// single shared link-controller TX app port.
interface slink_tx_arb_if #(
  parameter int NUM_REQ           = 2,
  parameter int TX_APP_DATA_WIDTH = 128
);
  logic [NUM_REQ-1:0]                   req_sop;
  logic [NUM_REQ*8-1:0]                 req_data_id;
  logic [NUM_REQ*16-1:0]                req_word_count;
  logic [NUM_REQ*TX_APP_DATA_WIDTH-1:0] req_app_data;
  logic [NUM_REQ-1:0]                   req_advance;
  logic                                 tx_sop;
  logic [7:0]                           tx_data_id;
  logic [15:0]                          tx_word_count;
  logic [TX_APP_DATA_WIDTH-1:0]         tx_app_data;
  logic                                 tx_advance;

  modport master (
    output req_sop, req_data_id, req_word_count,
    output req_app_data, tx_advance,
    input  req_advance, tx_sop, tx_data_id,
    input  tx_word_count, tx_app_data
  );

  modport slave (
    input  req_sop, req_data_id, req_word_count,
    input  req_app_data, tx_advance,
    output req_advance, tx_sop, tx_data_id,
    output tx_word_count, tx_app_data
  );
endinterface

// File: rtl/slink_tx_arb.sv
// Round-robin arbiter sharing one S-Link TX app packet port between
// NUM_REQ sources; grant is held for the packet's beat count.
module slink_tx_arb #(
  parameter int         NUM_REQ           = 2,
  parameter int         TX_APP_DATA_WIDTH = 128,
  parameter logic [7:0] SHORT_PKT_MAX     = 8'h20,
  localparam int        IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic          link_clk,
  input  logic          link_reset,
  input  logic          enable,
  slink_tx_arb_if.slave bus,
  output logic          busy,
  output logic [IW-1:0] grant_idx,
  output logic          abort
);
  localparam int DW  = TX_APP_DATA_WIDTH;
  localparam int BPB = DW / 8;
  localparam int LB  = $clog2(BPB);
  localparam int CW  = 17;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   scan;
  logic            pick_vld;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   beat_ld;
  logic [CW-1:0]   sum;
  logic [CW-1:0]   ceil_b;
  logic            gsop;
  logic            load;

  logic [7:0]      ids  [NUM_REQ];
  logic [15:0]     wcs  [NUM_REQ];
  logic [DW-1:0]   dats [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ids[i]  = bus.req_data_id[i*8 +: 8];
      wcs[i]  = bus.req_word_count[i*16 +: 16];
      dats[i] = bus.req_app_data[i*DW +: DW];
    end
  end

  // Scan downward so the lowest offset from ptr+1 wins last.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan = IW'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_sop[scan]) begin
        pick_vld = 1'b1;
        pick     = scan;
      end
    end
  end

  // 17-bit sum keeps wc=16'hFFFF from wrapping.
  always_comb begin
    sum    = {1'b0, wcs[pick]} + CW'(BPB - 1);
    ceil_b = sum >> LB;
    if (ids[pick] < SHORT_PKT_MAX)
      beat_ld = CW'(1);
    else if (ceil_b == '0)
      beat_ld = CW'(1);
    else
      beat_ld = ceil_b;
  end

  assign gsop = bus.req_sop[grant_idx];
  assign load = (state == IDLE) && (state_nx == BUSY);

  always_ff @(posedge link_clk or posedge link_reset) begin
    if (link_reset) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (enable && pick_vld) state_nx = BUSY;
      BUSY: begin
        if (!gsop)
          state_nx = IDLE;
        else if (bus.tx_advance && beat_cnt == CW'(1))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge link_clk or posedge link_reset) begin
    if (link_reset) begin
      grant_idx <= '0;
      ptr       <= IW'(NUM_REQ - 1);
      beat_cnt  <= '0;
    end else if (load) begin
      grant_idx <= pick;
      ptr       <= pick;
      beat_cnt  <= beat_ld;
    end else if (state == BUSY && bus.tx_advance) begin
      beat_cnt  <= beat_cnt - CW'(1);
    end
  end

  always_comb begin
    busy              = (state == BUSY);
    abort             = busy && !gsop;
    bus.tx_sop        = busy && gsop;
    bus.tx_data_id    = '0;
    bus.tx_word_count = '0;
    bus.tx_app_data   = '0;
    bus.req_advance   = '0;
    if (busy) begin
      bus.tx_data_id             = ids[grant_idx];
      bus.tx_word_count          = wcs[grant_idx];
      bus.tx_app_data            = dats[grant_idx];
      bus.req_advance[grant_idx] = bus.tx_advance;
    end
  end
endmodule

// File: tb/tb_slink_tx_arb.sv
// Bench for slink_tx_arb: directed scenarios plus a randomized
// round-robin run checked by a scoreboard and monitor.
module tb_slink_tx_arb;
  localparam int NR = 3;
  localparam int DW = 128;
  localparam int IW = 2;

  typedef struct {
    int          idx;
    int          seq;
    logic [7:0]  id;
    logic [15:0] wc;
    int          beats;
  } exp_t;

  logic          link_clk;
  logic          link_reset;
  logic          enable;
  logic          busy;
  logic [IW-1:0] grant_idx;
  logic          abort;

  slink_tx_arb_if #(.NUM_REQ(NR), .TX_APP_DATA_WIDTH(DW)) bus ();

  slink_tx_arb #(
    .NUM_REQ(NR), .TX_APP_DATA_WIDTH(DW), .SHORT_PKT_MAX(8'h20)
  ) dut (
    .link_clk(link_clk), .link_reset(link_reset), .enable(enable),
    .bus(bus), .busy(busy), .grant_idx(grant_idx), .abort(abort)
  );

  initial link_clk = 1'b0;
  always #5 link_clk = ~link_clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  bit   mon_on = 1'b0;
  bit   in_pkt = 1'b0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_beats(logic [7:0] id, logic [15:0] wc);
    int b;
    if (id < 8'h20) return 1;
    b = (int'(wc) + 15) / 16;
    return (b == 0) ? 1 : b;
  endfunction

  function automatic logic [127:0] mk_data(int i, int s, int b);
    return {32'(i), 32'(s), 32'(b), 32'hC0DE_0000 ^ 32'(s * 7 + b)};
  endfunction

  task automatic set_req(int i, bit sop, logic [7:0] id,
                         logic [15:0] wc, logic [127:0] d);
    bus.req_sop[i]                = sop;
    bus.req_data_id[i*8 +: 8]     = id;
    bus.req_word_count[i*16 +: 16] = wc;
    bus.req_app_data[i*DW +: DW]  = d;
  endtask

  task automatic tick();
    @(posedge link_clk);
    #1;
  endtask

  task automatic do_reset();
    link_reset = 1'b1;
    repeat (2) @(posedge link_clk);
    #1 link_reset = 1'b0;
    #1;
  endtask

  task automatic run_pkt(int i, logic [7:0] id, logic [15:0] wc,
                         output int n);
    set_req(i, 1'b1, id, wc, '0);
    bus.tx_advance = 1'b1;
    tick();
    n = 0;
    while (busy && n < 5000) begin
      n++;
      tick();
    end
    set_req(i, 1'b0, 8'h00, 16'h0, '0);
    bus.tx_advance = 1'b0;
  endtask

  // Monitor: reconstructs each granted packet and pops the scoreboard.
  int          m_g, m_nb;
  logic [7:0]  m_id;
  logic [15:0] m_wc;
  bit          m_ab;
  always @(negedge link_clk) begin
    exp_t e;
    if (mon_on) begin
      if (busy) begin
        if (!in_pkt) begin
          in_pkt = 1'b1;
          m_g  = int'(grant_idx);
          m_id = bus.tx_data_id;
          m_wc = bus.tx_word_count;
          m_nb = 0;
          m_ab = 1'b0;
          if (exp_q.size() == 0)
            chk("sb_unexpected_pkt", 1, 0);
        end
        if (abort) m_ab = 1'b1;
        chk("sb_req_adv",
            bus.req_advance,
            bus.tx_advance ? (128'(1) << m_g) : 128'(0));
        if (bus.tx_advance && bus.tx_sop) begin
          if (exp_q.size() > 0)
            chk("sb_data", bus.tx_app_data,
                mk_data(exp_q[0].idx, exp_q[0].seq, m_nb));
          m_nb++;
        end
      end else begin
        chk("sb_idle_adv", bus.req_advance, 0);
        if (in_pkt) begin
          in_pkt = 1'b0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_grant", m_g, e.idx);
            chk("sb_id", m_id, e.id);
            chk("sb_wc", m_wc, e.wc);
            chk("sb_beats", m_nb, e.beats);
            chk("sb_abort", m_ab, 0);
          end
        end
      end
    end
  end

  int          npk [NR];
  int          cur [NR];
  int          bt  [NR];
  logic [7:0]  pid [NR][16];
  logic [15:0] pwc [NR][16];

  task automatic drive_rq(int i);
    if (cur[i] < npk[i])
      set_req(i, 1'b1, pid[i][cur[i]], pwc[i][cur[i]],
              mk_data(i, cur[i], bt[i]));
    else
      set_req(i, 1'b0, 8'h00, 16'h0, '0);
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NR; i++)
      if (cur[i] < npk[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int n;
    int last;
    int rem [NR];
    int cyc;
    logic [NR-1:0] adv;
    exp_t e;

    link_reset     = 1'b1;
    enable         = 1'b1;
    bus.req_sop    = '0;
    bus.req_data_id = '0;
    bus.req_word_count = '0;
    bus.req_app_data = '0;
    bus.tx_advance = 1'b0;
    do_reset();

    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_abort", abort, 0);
    chk("rst_sop", bus.tx_sop, 0);
    chk("rst_adv", bus.req_advance, 0);
    chk("rst_id", bus.tx_data_id, 0);
    chk("rst_wc", bus.tx_word_count, 0);
    chk("rst_data", bus.tx_app_data, 0);

    // single long packet of one beat
    set_req(0, 1'b1, 8'h30, 16'd16, 128'hABCD);
    tick();
    chk("t1_sop", bus.tx_sop, 1);
    chk("t1_busy", busy, 1);
    chk("t1_id", bus.tx_data_id, 8'h30);
    chk("t1_data", bus.tx_app_data, 128'hABCD);
    bus.tx_advance = 1'b1;
    #1;
    chk("t1_adv", bus.req_advance, 3'b001);
    tick();
    set_req(0, 1'b0, 8'h00, 16'h0, '0);
    bus.tx_advance = 1'b0;
    #1;
    chk("t1_busy_drop", busy, 0);
    chk("t1_grant", grant_idx, 0);
    chk("t1_idle_id", bus.tx_data_id, 0);

    // two short requesters alternate with a bubble
    do_reset();
    set_req(0, 1'b1, 8'h05, 16'd0, '0);
    set_req(1, 1'b1, 8'h05, 16'd0, '0);
    bus.tx_advance = 1'b1;
    for (int p = 0; p < 4; p++) begin
      tick();
      chk("t2_busy", busy, 1);
      chk("t2_grant", grant_idx, p % 2);
      chk("t2_adv", bus.req_advance, 3'(1 << (p % 2)));
      tick();
      chk("t2_bubble", busy, 0);
      chk("t2_bubble_adv", bus.req_advance, 0);
    end
    set_req(0, 1'b0, 8'h00, 16'h0, '0);
    set_req(1, 1'b0, 8'h00, 16'h0, '0);
    bus.tx_advance = 1'b0;

    // beat-count boundaries
    do_reset();
    run_pkt(0, 8'h30, 16'd40, n);
    chk("t3_wc40", n, 3);
    run_pkt(0, 8'h30, 16'd0, n);
    chk("t3_wc0", n, 1);
    run_pkt(0, 8'h30, 16'hFFFF, n);
    chk("t3_wcffff", n, 4096);
    run_pkt(0, 8'h1F, 16'd200, n);
    chk("t3_short", n, 1);

    // grantee drops mid-packet
    do_reset();
    set_req(1, 1'b1, 8'h30, 16'd40, '0);
    tick();
    chk("t4_grant1", grant_idx, 1);
    bus.tx_advance = 1'b1;
    tick();
    bus.tx_advance = 1'b0;
    set_req(1, 1'b0, 8'h00, 16'h0, '0);
    set_req(0, 1'b1, 8'h05, 16'd0, '0);
    #1;
    chk("t4_abort", abort, 1);
    tick();
    chk("t4_abort_pulse", abort, 0);
    chk("t4_idle", busy, 0);
    tick();
    chk("t4_next_busy", busy, 1);
    chk("t4_next_grant", grant_idx, 0);
    bus.tx_advance = 1'b1;
    tick();
    set_req(0, 1'b0, 8'h00, 16'h0, '0);
    bus.tx_advance = 1'b0;

    // enable drop does not truncate
    do_reset();
    set_req(0, 1'b1, 8'h30, 16'd40, '0);
    set_req(1, 1'b1, 8'h05, 16'd0, '0);
    tick();
    enable = 1'b0;
    bus.tx_advance = 1'b1;
    tick();
    tick();
    chk("t5_still_busy", busy, 1);
    tick();
    chk("t5_done", busy, 0);
    set_req(0, 1'b0, 8'h00, 16'h0, '0);
    bus.tx_advance = 1'b0;
    repeat (3) tick();
    chk("t5_no_grant", busy, 0);
    enable = 1'b1;
    tick();
    chk("t5_grant", busy, 1);
    chk("t5_grant_idx", grant_idx, 1);
    bus.tx_advance = 1'b1;
    tick();
    set_req(1, 1'b0, 8'h00, 16'h0, '0);
    bus.tx_advance = 1'b0;

    // async reset mid-packet
    do_reset();
    set_req(1, 1'b1, 8'h30, 16'd40, '0);
    tick();
    set_req(0, 1'b1, 8'h30, 16'd40, '0);
    bus.tx_advance = 1'b1;
    #2 link_reset = 1'b1;
    #1;
    chk("t6_sop", bus.tx_sop, 0);
    chk("t6_busy", busy, 0);
    chk("t6_adv", bus.req_advance, 0);
    chk("t6_abort", abort, 0);
    @(negedge link_clk);
    link_reset = 1'b0;
    bus.tx_advance = 1'b0;
    tick();
    chk("t6_prio", grant_idx, 0);
    set_req(0, 1'b0, 8'h00, 16'h0, '0);
    set_req(1, 1'b0, 8'h00, 16'h0, '0);

    // randomized run with persistent requesters
    do_reset();
    for (int i = 0; i < NR; i++) begin
      npk[i] = $urandom_range(3, 8);
      cur[i] = 0;
      bt[i]  = 0;
      for (int j = 0; j < npk[i]; j++) begin
        if ($urandom_range(0, 1) == 0)
          pid[i][j] = 8'($urandom_range(0, 31));
        else
          pid[i][j] = 8'($urandom_range(32, 255));
        if ($urandom_range(0, 4) == 0)
          pwc[i][j] = 16'($urandom_range(0, 300));
        else
          pwc[i][j] = 16'($urandom_range(0, 100));
      end
      rem[i] = npk[i];
    end
    last = NR - 1;
    while (rem[0] + rem[1] + rem[2] > 0) begin
      for (int k = 1; k <= NR; k++) begin
        n = (last + k) % NR;
        if (rem[n] > 0) break;
      end
      e.idx   = n;
      e.seq   = npk[n] - rem[n];
      e.id    = pid[n][e.seq];
      e.wc    = pwc[n][e.seq];
      e.beats = exp_beats(e.id, e.wc);
      exp_q.push_back(e);
      rem[n]--;
      last = n;
    end

    for (int i = 0; i < NR; i++) drive_rq(i);
    mon_on = 1'b1;
    cyc = 0;
    while (!(all_done() && exp_q.size() == 0 && !in_pkt)
           && cyc < 20000) begin
      @(negedge link_clk);
      adv = bus.req_advance;
      @(posedge link_clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (adv[i] && cur[i] < npk[i]) begin
          bt[i]++;
          if (bt[i] == exp_beats(pid[i][cur[i]], pwc[i][cur[i]])) begin
            cur[i]++;
            bt[i] = 0;
          end
        end
        drive_rq(i);
      end
      bus.tx_advance = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      cyc++;
    end
    chk("sb_timeout", cyc < 20000, 1);
    chk("sb_drained", exp_q.size(), 0);
    mon_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/slink_tx_arb.md
Name: slink_tx_arb

Overview:
Round-robin arbiter that shares one S-Link application TX packet port (tx_sop/tx_data_id/tx_word_count/tx_app_data/tx_advance) between NUM_REQ packet sources, for example the APB bridge initiator/target plus other application engines.
- Grants one requester at a time and holds the grant for the whole packet by counting tx_advance beats.
- Muxes the granted requester's fields onto the link port and routes tx_advance back to that requester only.
- Sits in the link_clk domain, between the application packet sources and the S-Link controller TX app interface.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
TX_APP_DATA_WIDTH, 128, app data bus width in bits; must be a power of two and at least 8.
SHORT_PKT_MAX, 8'h20, data_id values below this are short packets.

Ports:
link_clk  in  1  link clock.
link_reset  in  1  asynchronous active-high reset.
enable  in  1  allow new grants; 0 lets the current packet finish, then the block idles.
req_sop  in  NUM_REQ  per-requester packet request; held high for the entire packet.
req_data_id  in  NUM_REQ*8  packed data IDs; requester i uses bits [8i+7:8i].
req_word_count  in  NUM_REQ*16  packed word counts (bytes).
req_app_data  in  NUM_REQ*TX_APP_DATA_WIDTH  packed payload.
req_advance  out  NUM_REQ  per-requester advance (tx_advance gated by grant).
tx_sop  out  1  to link controller.
tx_data_id  out  8  to link controller.
tx_word_count  out  16  to link controller.
tx_app_data  out  TX_APP_DATA_WIDTH  to link controller.
tx_advance  in  1  beat accepted by link controller.
busy  out  1  packet in progress.
grant_idx  out  $clog2(NUM_REQ) (min 1)  index of the current or most recent grantee.
abort  out  1  one-cycle pulse: grantee dropped req_sop mid-packet.

Behaviour:
Reset values:
- busy=0, grant_idx=0, abort=0, tx_sop=0, req_advance=0; tx_data_id, tx_word_count and tx_app_data are 0.
- Round-robin pointer resets to NUM_REQ-1, so requester 0 wins first.

FSM, two states:
- IDLE: if enable=1 and any req_sop bit is set, pick the first set bit scanning from pointer+1 upward with wrap.
  - Register grant_idx and the pointer.
  - Load beat_cnt: 1 if data_id < SHORT_PKT_MAX; otherwise max(1, ceil(word_count / (TX_APP_DATA_WIDTH/8))), computed as (wc + BPB-1) >> log2(BPB) on 17-bit arithmetic so that wc=16'hFFFF does not overflow.
  - Go to BUSY.
- BUSY: busy=1 and tx_sop = req_sop[grant_idx].
  - On each tx_advance, decrement beat_cnt. When tx_advance occurs with beat_cnt==1, go to IDLE.
  - If req_sop[grant_idx]==0 while in BUSY: pulse abort for one cycle, go to IDLE, beat_cnt is discarded.

Latency and muxing:
- Request to tx_sop is 1 cycle: the grant is registered in IDLE and tx_sop rises in the first BUSY cycle.
- There is one mandatory IDLE cycle between packets, so back-to-back packets have a 1-cycle bubble.
- In BUSY, tx_data_id, tx_word_count and tx_app_data combinationally mux the granted requester's fields; in IDLE they drive 0.
- req_advance[grant_idx] = tx_advance & BUSY; all other req_advance bits are 0. tx_advance seen in IDLE is ignored.

Boundaries:
- Simultaneous requests are served in round-robin order. A requester re-requesting right after its own packet loses to any other pending requester.
- enable falling in BUSY does not truncate the packet.
- A sole requester is granted repeatedly, with the 1-cycle bubble between packets.
- Reset mid-packet returns immediately to reset values; no abort pulse.
- Changes to the grantee's data_id or word_count in BUSY do not reload beat_cnt.

Test Plan:
1. Reset, then req_sop[0]=1, data_id=8'h30, wc=16 at DW=128 -> tx_sop on the next cycle, beat_cnt=1; tx_advance once -> req_advance[0] pulses, busy drops the following cycle, grant_idx=0.
2. req_sop=2'b11 both held, with short packets (data_id 8'h05) -> grants alternate 0,1,0,1; one idle cycle between packets; req_advance is never asserted on the non-granted index.
3. Long packet, wc=40 (BPB=16) -> exactly 3 tx_advance pulses are consumed before IDLE. wc=0 with data_id 8'h30 -> 1 beat. wc=16'hFFFF -> 4096 beats, no overflow.
4. Requester 1 drops req_sop after 1 of 3 beats -> abort pulses for one cycle, block returns to IDLE, requester 0 is granted next.
5. enable=0 while a 3-beat packet is in flight with req_sop[1] pending -> the packet completes, then no grant while enable=0; enable=1 -> requester 1 is granted.
6. Assert link_reset mid-packet (async, between clock edges) -> tx_sop, busy and req_advance are 0 immediately; after release, requester 0 has first priority again.
